lut_arbiter: RTL and testbench
==============================

Name: lut_arbiter

Overview:
- Shares the single combinational constant/immediate LUT read port (4-bit index -> 8-bit value) between NUM_REQ requesters, e.g. the decode stage and a multi-cycle sequencer.
- Round-robin arbitration; valid/ready handshake on request and response.
- Drives the LUT index, captures the LUT output into a one-entry response register, and flags out-of-range indices.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- ADDR_W, 4: LUT index width.
- DATA_W, 8: LUT data width.
- NUM_ENTRIES, 12: count of defined LUT entries. Index >= NUM_ENTRIES is an error.
- CNT_W, 16: width of the lookup counter.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset (asserted when 0).
- req_valid  input  NUM_REQ  per-requester lookup request.
- req_addr  input  NUM_REQ*ADDR_W  packed indices; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_ready  output  NUM_REQ  one-hot accept; combinational.
- lut_addr  output  ADDR_W  index to the LUT; combinational.
- lut_data  input  DATA_W  LUT output; combinational function of lut_addr.
- rsp_valid  output  NUM_REQ  one-hot response valid, routed to the owning requester.
- rsp_data  output  DATA_W  registered looked-up value.
- rsp_err  output  1  registered; 1 when the accepted index was >= NUM_ENTRIES.
- rsp_ready  input  NUM_REQ  per-requester response consume.
- lookup_cnt  output  CNT_W  saturating count of accepted lookups.

Behaviour:
- Reset (Reset==0 at a rising edge):
  - rsp_valid=0, rsp_data=0, rsp_err=0, lookup_cnt=0.
  - state=IDLE; round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Reset overrides everything, including an in-flight HOLD response, which is dropped.
- States:
  - IDLE: no response held.
  - HOLD: response register valid, owner index stored.
- can_accept = (state==IDLE) | (state==HOLD & rsp_ready[owner]).
- Grant, combinational:
  - Search starts at (last+1) mod NUM_REQ and takes the first asserted req_valid.
  - grant is valid only if can_accept.
  - req_ready[g]=1 for the granted index only. All other bits are 0; all bits are 0 if there is no grant.
- lut_addr = req_addr of the granted requester. It is 0 when there is no grant, so the LUT input never floats to x.
- On an accept edge (grant exists):
  - rsp_data <= lut_data, or 0 if the index >= NUM_ENTRIES.
  - rsp_err <= (index >= NUM_ENTRIES).
  - owner <= g; last <= g; state <= HOLD.
  - lookup_cnt increments and saturates at all-ones.
- Latency: rsp_valid[owner]=1 exactly one cycle after the accept edge.
- Throughput: 1 lookup/cycle. A HOLD response consumed in the same cycle as a new accept is replaced without a bubble.
- HOLD with rsp_ready[owner]=0 and no accept: rsp_data, rsp_err and owner are stable. req_ready is all 0.
- HOLD with rsp_ready[owner]=1 and no request: state <= IDLE, rsp_valid <= 0.
- rsp_ready bits of non-owners are ignored.
- A requester may hold req_valid across cycles. It is served only when granted; its address must stay stable until req_ready is seen.
- Simultaneous requests: round-robin guarantees each persistently requesting requester is granted within NUM_REQ accepts.
- Single requester: it is granted on every cycle where can_accept holds; the pointer does not block it.
- rsp_err is meaningful only while rsp_valid is nonzero.

Test Plan:
- Reset, then req_valid=01 with addr0=3 and a LUT model (3->8), rsp_ready=1 -> req_ready=01 in cycle 0; rsp_valid=01, rsp_data=8, rsp_err=0 in cycle 1; lookup_cnt=1.
- Both requesters valid every cycle (addr0=9->30, addr1=11->0xFF), rsp_ready=11 -> grants alternate 0,1,0,1; rsp_data alternates 30, 0xFF; no idle cycles; lookup_cnt=4 after 4 accepts.
- Response backpressure: accept addr 4 (->16), hold rsp_ready=0 for 3 cycles with req1 valid -> rsp_data stays 16, req_ready=00, rsp_valid=01. Release -> req1 accepted the same cycle; next cycle rsp_valid=10.
- Out-of-range: addr0=12 and addr0=15 -> rsp_data=0, rsp_err=1. Next lookup addr0=8 (->0) -> rsp_err=0.
- Reset asserted (Reset=0) while in HOLD with an unconsumed response -> next cycle rsp_valid=0, rsp_data=0, lookup_cnt=0. The first post-reset grant with both requesting goes to requester 0.
- Counter saturation with CNT_W=4: 20 back-to-back accepts -> lookup_cnt=15, no wrap.

Source files
------------

// File: rtl/lut_arbiter.sv
// lut_arbiter: round-robin sharing of one combinational LUT read port among
// NUM_REQ requesters. Each accepted lookup is captured into a one-entry
// response register and returned to its owner over a valid/ready handshake.
// Indices at or beyond NUM_ENTRIES are flagged as errors and read as zero.
module lut_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int NUM_ENTRIES = 12,
  parameter int CNT_W       = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         lut_addr,
  input  logic [DATA_W-1:0]         lut_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [CNT_W-1:0]          lookup_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so that NUM_ENTRIES == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] ENTRY_LIM = (ADDR_W+1)'(NUM_ENTRIES);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e              state_q,    state_d;
  logic [IDX_W-1:0]    owner_q,    owner_d;
  logic [IDX_W-1:0]    last_q,     last_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q,  rsp_err_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;

  logic                can_accept;
  logic                grant_found;
  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;
  logic                addr_err;

  // Round-robin search starting just after the last granted requester.
  // NOTE: every variable written in an always_comb block gets a default on
  // entry; a path that leaves one unassigned would infer a latch.
  always_comb begin
    logic [IDX_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + 1 + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Grant qualification, LUT index drive and one-hot ready/valid routing.
  always_comb begin
    can_accept  = (state_q == IDLE) || rsp_ready[owner_q];
    grant_valid = grant_found && can_accept;
    req_ready   = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
    // Driving zero when idle keeps the LUT input from ever floating to x.
    lut_addr    = grant_valid ? req_addr[grant_idx*ADDR_W +: ADDR_W] : '0;
    addr_err    = ({1'b0, lut_addr} >= ENTRY_LIM);
    rsp_valid   = (state_q == HOLD) ? (NUM_REQ'(1) << owner_q) : '0;
    rsp_data    = rsp_data_q;
    rsp_err     = rsp_err_q;
    lookup_cnt  = cnt_q;
  end

  // Next-state logic: accept replaces the held response without a bubble,
  // otherwise a consumed response returns the block to IDLE.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cnt_d      = cnt_q;
    if (grant_valid) begin
      state_d    = HOLD;
      owner_d    = grant_idx;
      last_d     = grant_idx;
      rsp_data_d = addr_err ? '0 : lut_data;
      rsp_err_d  = addr_err;
      cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (state_q == HOLD && rsp_ready[owner_q]) begin
      state_d = IDLE;
    end
  end

  // State registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lut_arbiter.sv
// Directed bench for lut_arbiter: single lookup, alternating round-robin,
// response backpressure, out-of-range indices, reset while holding, and
// counter saturation on a narrow-counter instance.
module tb_lut_arbiter;

  logic       Clk;
  logic       Reset;

  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_addr;
  logic [3:0] lut_addr;
  logic [7:0] lut_data, rsp_data;
  logic       rsp_err;
  logic [15:0] lookup_cnt;

  logic [1:0] s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
  logic [7:0] s_req_addr;
  logic [3:0] s_lut_addr;
  logic [7:0] s_lut_data, s_rsp_data;
  logic       s_rsp_err;
  logic [3:0] s_lookup_cnt;

  logic [7:0] lut_mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  assign lut_data   = lut_mem[lut_addr];
  assign s_lut_data = lut_mem[s_lut_addr];

  lut_arbiter #(.NUM_REQ(2), .ADDR_W(4), .DATA_W(8), .NUM_ENTRIES(12), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .lut_addr(lut_addr), .lut_data(lut_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .lookup_cnt(lookup_cnt)
  );

  lut_arbiter #(.NUM_REQ(2), .ADDR_W(4), .DATA_W(8), .NUM_ENTRIES(12), .CNT_W(4)) dut_s (
    .Clk(Clk), .Reset(Reset),
    .req_valid(s_req_valid), .req_addr(s_req_addr), .req_ready(s_req_ready),
    .lut_addr(s_lut_addr), .lut_data(s_lut_data),
    .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data), .rsp_err(s_rsp_err),
    .rsp_ready(s_rsp_ready), .lookup_cnt(s_lookup_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are stable here.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    Reset     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    step();
    Reset = 1'b1;
  endtask

  initial begin
    // LUT contents; 12..15 are nonzero so out-of-range zeroing is visible.
    lut_mem = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128,
                8'd0, 8'd30, 8'd100, 8'hFF, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    Reset = 1'b0;
    req_valid = '0; req_addr = '0; rsp_ready = '0;
    s_req_valid = '0; s_req_addr = '0; s_rsp_ready = '0;
    step();
    step();

    // Reset state
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_data", rsp_data, 8'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_cnt", lookup_cnt, 16'd0);
    check("rst_lut_addr", lut_addr, 4'd0);
    Reset = 1'b1;

    // Single lookup: addr0=3 -> 8
    req_valid = 2'b01; req_addr = {4'd0, 4'd3}; rsp_ready = 2'b01;
    settle();
    check("t1_req_ready", req_ready, 2'b01);
    check("t1_lut_addr", lut_addr, 4'd3);
    step();
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_rsp_data", rsp_data, 8'd8);
    check("t1_rsp_err", rsp_err, 1'b0);
    check("t1_cnt", lookup_cnt, 16'd1);
    req_valid = 2'b00;
    step();
    check("t1_drain_valid", rsp_valid, 2'b00);

    // Alternating round-robin with both requesters persistent
    do_reset();
    req_valid = 2'b11; req_addr = {4'd11, 4'd9}; rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("t2_req_ready_%0d", i), req_ready, (i % 2) ? 2'b10 : 2'b01);
      step();
      check($sformatf("t2_rsp_valid_%0d", i), rsp_valid, (i % 2) ? 2'b10 : 2'b01);
      check($sformatf("t2_rsp_data_%0d", i), rsp_data, (i % 2) ? 8'hFF : 8'd30);
    end
    check("t2_cnt", lookup_cnt, 16'd4);
    req_valid = 2'b00;
    step();
    check("t2_drain_valid", rsp_valid, 2'b00);

    // Backpressure: hold addr0=4 (->16) while req1 waits; non-owner ready ignored
    do_reset();
    req_valid = 2'b01; req_addr = {4'd5, 4'd4}; rsp_ready = 2'b00;
    settle();
    check("t3_req_ready_first", req_ready, 2'b01);
    step();
    check("t3_rsp_data_first", rsp_data, 8'd16);
    req_valid = 2'b10; rsp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("t3_req_ready_hold_%0d", i), req_ready, 2'b00);
      step();
      check($sformatf("t3_rsp_valid_hold_%0d", i), rsp_valid, 2'b01);
      check($sformatf("t3_rsp_data_hold_%0d", i), rsp_data, 8'd16);
    end
    rsp_ready = 2'b01;
    settle();
    check("t3_req_ready_release", req_ready, 2'b10);
    step();
    check("t3_rsp_valid_next", rsp_valid, 2'b10);
    check("t3_rsp_data_next", rsp_data, 8'd32);
    check("t3_cnt", lookup_cnt, 16'd2);
    req_valid = 2'b00; rsp_ready = 2'b10;
    step();
    check("t3_drain_valid", rsp_valid, 2'b00);

    // Out-of-range indices, back-to-back on one requester
    req_valid = 2'b01; rsp_ready = 2'b01;
    req_addr = {4'd0, 4'd12};
    step();
    check("t4_data_12", rsp_data, 8'd0);
    check("t4_err_12", rsp_err, 1'b1);
    check("t4_valid_12", rsp_valid, 2'b01);
    req_addr = {4'd0, 4'd15};
    settle();
    check("t4_ready_15", req_ready, 2'b01);
    step();
    check("t4_data_15", rsp_data, 8'd0);
    check("t4_err_15", rsp_err, 1'b1);
    req_addr = {4'd0, 4'd8};
    step();
    check("t4_data_8", rsp_data, 8'd0);
    check("t4_err_8", rsp_err, 1'b0);
    check("t4_cnt", lookup_cnt, 16'd5);
    req_valid = 2'b00;
    step();

    // Reset while holding an unconsumed response
    req_valid = 2'b11; req_addr = {4'd11, 4'd9}; rsp_ready = 2'b00;
    step();
    check("t5_hold_valid", rsp_valid, 2'b10);
    Reset = 1'b0;
    step();
    check("t5_rst_valid", rsp_valid, 2'b00);
    check("t5_rst_data", rsp_data, 8'd0);
    check("t5_rst_cnt", lookup_cnt, 16'd0);
    Reset = 1'b1; rsp_ready = 2'b11;
    settle();
    check("t5_first_grant", req_ready, 2'b01);
    step();
    check("t5_post_valid", rsp_valid, 2'b01);
    check("t5_post_data", rsp_data, 8'd30);
    req_valid = 2'b00;
    step();

    // Counter saturation on the 4-bit counter instance
    s_req_valid = 2'b01; s_req_addr = {4'd0, 4'd3}; s_rsp_ready = 2'b01;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("t6_cnt_%0d", i), s_lookup_cnt, (i < 15) ? 32'(i + 1) : 32'd15);
    end
    check("t6_valid", s_rsp_valid, 2'b01);
    check("t6_data", s_rsp_data, 8'd8);
    s_req_valid = 2'b00;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
